// File: rtl/bs_pkg.sv
// Shared types, constants and helpers for the battleship master controller.
//   state_t      : game sequencer states
//   W_NONE/W_A/W_B : winner encodings
//   NCELLS_DEF   : default grid size (4x4, one bit per cell)
//   popcount16   : number of set bits in a 16-bit cell mask
//   is_onehot16  : true when exactly one cell is selected
package bs_pkg;

  localparam int unsigned NCELLS_DEF = 16;

  typedef enum logic [2:0] {
    S_PLACE,
    S_START,
    S_A_TURN,
    S_A_RES,
    S_B_TURN,
    S_B_RES,
    S_OVER
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_A    = 2'b01;
  localparam logic [1:0] W_B    = 2'b10;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic is_onehot16(input logic [15:0] v);
    return popcount16(v) == 5'd1;
  endfunction

endpackage

// File: rtl/bs_turn_timer.sv
// Per-turn watchdog counter.
//   clk, clr_n  : clock, async active-low reset
//   i_clear     : synchronous clear (highest priority)
//   i_en        : count while a player is on move
//   o_expire_c  : combinational, high in the last allowed cycle of a turn
module bs_turn_timer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  // Saturates at LAST so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire_c = i_en && (r_count == LAST);

endmodule

// File: rtl/master_game_ctrl.sv
// Master-board game sequencer: collects both fleets, alternates turns,
// resolves shots against the opposing fleet and declares the winner.
//   clk, clr_n           : clock, async active-low reset
//   place_a, ok_a        : master fleet switches and confirm pulse
//   btn_fire, cursor     : master fire pulse and target cell
//   ok_b                 : slave confirm / attack-valid pulse
//   board_b_in, b_attack : slave fleet (placement) and one-hot attack
//   a_map, b_map         : A's hits on B, B's hits on A
//   ldr1b, ldr2b, st     : fleet-latched and game-start strobes
//   turn_b               : 0 = A to move, 1 = B to move
//   live_a, live_b       : fleet still has unhit cells
//   winner, err          : result code, rejected-input pulse
module master_game_ctrl
  import bs_pkg::*;
#(
  parameter int unsigned NCELLS      = NCELLS_DEF,
  parameter int unsigned SHIP_CELLS  = 3,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NCELLS-1:0] place_a,
  input  logic              ok_a,
  input  logic              btn_fire,
  input  logic [3:0]        cursor,
  input  logic              ok_b,
  input  logic [NCELLS-1:0] board_b_in,
  input  logic [NCELLS-1:0] b_attack,
  output logic [NCELLS-1:0] a_map,
  output logic [NCELLS-1:0] b_map,
  output logic              ldr1b,
  output logic              ldr2b,
  output logic              st,
  output logic              turn_b,
  output logic              live_a,
  output logic              live_b,
  output logic [1:0]        winner,
  output logic              err
);

  state_t            r_state;
  logic [NCELLS-1:0] r_fleet_a, r_fleet_b;
  logic [NCELLS-1:0] r_shots_a, r_shots_b;
  logic [NCELLS-1:0] r_a_map, r_b_map;
  logic              r_rdy_a, r_rdy_b;
  logic              r_ldr1b, r_ldr2b, r_st, r_turn_b, r_err;
  logic              r_live_a, r_live_b;
  logic [1:0]        r_winner;

  logic w_fleet_a_ok, w_fleet_b_ok;
  logic w_fire_ok, w_atk_ok;
  logic w_in_turn, w_expire, w_tmr_clear;

  assign w_fleet_a_ok = popcount16(16'(place_a))    == 5'(SHIP_CELLS);
  assign w_fleet_b_ok = popcount16(16'(board_b_in)) == 5'(SHIP_CELLS);

  // Valid shots: new cell for A, new one-hot cell for B.
  assign w_fire_ok = (r_state == S_A_TURN) && btn_fire && !r_shots_a[cursor];
  assign w_atk_ok  = (r_state == S_B_TURN) && ok_b && is_onehot16(16'(b_attack))
                     && ((b_attack & r_shots_b) == '0);

  // Timer runs only while someone is on move; every turn change restarts it.
  assign w_in_turn   = (r_state == S_A_TURN) || (r_state == S_B_TURN);
  assign w_tmr_clear = !w_in_turn || w_fire_ok || w_atk_ok || w_expire;

  bs_turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .clr_n      (clr_n),
    .i_clear    (w_tmr_clear),
    .i_en       (w_in_turn),
    .o_expire_c (w_expire)
  );

  // Game sequencer with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= S_PLACE;
      r_fleet_a <= '0;
      r_fleet_b <= '0;
      r_shots_a <= '0;
      r_shots_b <= '0;
      r_a_map   <= '0;
      r_b_map   <= '0;
      r_rdy_a   <= 1'b0;
      r_rdy_b   <= 1'b0;
      r_ldr1b   <= 1'b0;
      r_ldr2b   <= 1'b0;
      r_st      <= 1'b0;
      r_turn_b  <= 1'b0;
      r_err     <= 1'b0;
      r_live_a  <= 1'b1;
      r_live_b  <= 1'b1;
      r_winner  <= W_NONE;
    end else begin
      r_ldr1b <= 1'b0;
      r_ldr2b <= 1'b0;
      r_st    <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_PLACE: begin
          // Confirms after a fleet is already latched are silently dropped.
          if (ok_a && !r_rdy_a) begin
            if (w_fleet_a_ok) begin
              r_fleet_a <= place_a;
              r_rdy_a   <= 1'b1;
              r_ldr1b   <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (ok_b && !r_rdy_b) begin
            if (w_fleet_b_ok) begin
              r_fleet_b <= board_b_in;
              r_rdy_b   <= 1'b1;
              r_ldr2b   <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (r_rdy_a && r_rdy_b) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_state  <= S_A_TURN;
          r_st     <= 1'b1;
          r_turn_b <= 1'b0;
        end
        S_A_TURN: begin
          // A valid shot wins over a timeout landing in the same cycle.
          if (w_fire_ok) begin
            r_shots_a[cursor] <= 1'b1;
            r_a_map[cursor]   <= r_a_map[cursor] | r_fleet_b[cursor];
            r_state           <= S_A_RES;
          end else begin
            if (btn_fire) begin
              r_err <= 1'b1;
            end
            if (w_expire) begin
              r_state  <= S_B_TURN;
              r_turn_b <= 1'b1;
            end
          end
        end
        S_A_RES: begin
          if (r_a_map == r_fleet_b) begin
            r_state  <= S_OVER;
            r_winner <= W_A;
            r_live_b <= 1'b0;
          end else begin
            r_state  <= S_B_TURN;
            r_turn_b <= 1'b1;
          end
        end
        S_B_TURN: begin
          if (w_atk_ok) begin
            r_shots_b <= r_shots_b | b_attack;
            r_b_map   <= r_b_map | (b_attack & r_fleet_a);
            r_state   <= S_B_RES;
          end else begin
            if (ok_b) begin
              r_err <= 1'b1;
            end
            if (w_expire) begin
              r_state  <= S_A_TURN;
              r_turn_b <= 1'b0;
            end
          end
        end
        S_B_RES: begin
          if (r_b_map == r_fleet_a) begin
            r_state  <= S_OVER;
            r_winner <= W_B;
            r_live_a <= 1'b0;
          end else begin
            r_state  <= S_A_TURN;
            r_turn_b <= 1'b0;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_PLACE;
        end
      endcase
    end
  end

  assign a_map  = r_a_map;
  assign b_map  = r_b_map;
  assign ldr1b  = r_ldr1b;
  assign ldr2b  = r_ldr2b;
  assign st     = r_st;
  assign turn_b = r_turn_b;
  assign live_a = r_live_a;
  assign live_b = r_live_b;
  assign winner = r_winner;
  assign err    = r_err;

endmodule

// File: tb/tb_master_game_ctrl.sv
// Self-checking bench for master_game_ctrl: directed scenarios plus
// randomized full games checked against a cell-set model of the rules.
module tb_master_game_ctrl;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [15:0] place_a = '0;
  logic [15:0] board_b_in = '0;
  logic [15:0] b_attack = '0;
  logic        ok_a = 1'b0;
  logic        ok_b = 1'b0;
  logic        btn_fire = 1'b0;
  logic [3:0]  cursor = '0;

  logic [15:0] a_map, b_map;
  logic        ldr1b, ldr2b, st, turn_b, live_a, live_b, err;
  logic [1:0]  winner;

  int passed = 0;
  int total  = 0;

  master_game_ctrl #(
    .NCELLS(16), .SHIP_CELLS(3), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .clr_n(clr_n), .place_a(place_a), .ok_a(ok_a),
    .btn_fire(btn_fire), .cursor(cursor), .ok_b(ok_b),
    .board_b_in(board_b_in), .b_attack(b_attack),
    .a_map(a_map), .b_map(b_map), .ldr1b(ldr1b), .ldr2b(ldr2b),
    .st(st), .turn_b(turn_b), .live_a(live_a), .live_b(live_b),
    .winner(winner), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ok_a = 0; ok_b = 0; btn_fire = 0; b_attack = '0;
    clr_n = 1'b0;
    tick(); tick();
    #2 clr_n = 1'b1;
    tick();
  endtask

  // Place both fleets in one cycle; returns in the first A_TURN cycle.
  task automatic do_place(input logic [15:0] fa, input logic [15:0] fb);
    place_a = fa; board_b_in = fb; ok_a = 1; ok_b = 1;
    tick();
    ok_a = 0; ok_b = 0;
    tick(); tick();
  endtask

  function automatic logic [15:0] rand_fleet();
    logic [15:0] f;
    f = '0;
    for (int k = 0; k < 200 && $countones(f) < 3; k++) f[$urandom_range(0, 15)] = 1'b1;
    if ($countones(f) != 3) f = 16'h0007;
    return f;
  endfunction

  function automatic logic [15:0] rand_bad_fleet();
    logic [15:0] f;
    f = 16'($urandom);
    if ($countones(f) == 3) f = f | 16'h8001 | 16'h0300;
    return f;
  endfunction

  function automatic int pick_bit(input logic [15:0] v, input logic want);
    int s;
    s = int'($urandom_range(0, 15));
    for (int k = 0; k < 16; k++) if (v[(s + k) % 16] == want) return (s + k) % 16;
    return 0;
  endfunction

  task automatic test_reset();
    clr_n = 1'b0;
    tick(); tick();
    total++; if (a_map !== 16'h0 || b_map !== 16'h0) $display("FAIL reset_maps got=%h/%h exp=0000/0000", a_map, b_map); else passed++;
    total++; if ({ldr1b, ldr2b, st, err} !== 4'b0) $display("FAIL reset_strobes got=%b exp=0000", {ldr1b, ldr2b, st, err}); else passed++;
    total++; if (turn_b !== 1'b0 || winner !== 2'b00) $display("FAIL reset_turn_winner got=%b/%b exp=0/00", turn_b, winner); else passed++;
    total++; if (live_a !== 1'b1 || live_b !== 1'b1) $display("FAIL reset_live got=%b%b exp=11", live_a, live_b); else passed++;
    #2 clr_n = 1'b1;
    tick();
  endtask

  task automatic test_placement();
    place_a = 16'h000F; ok_a = 1; tick(); ok_a = 0;
    total++; if (err !== 1'b1) $display("FAIL bad_fleet_err got=%b exp=1", err); else passed++;
    total++; if (ldr1b !== 1'b0) $display("FAIL bad_fleet_ldr1b got=%b exp=0", ldr1b); else passed++;
    place_a = 16'h0007; ok_a = 1; tick(); ok_a = 0;
    total++; if (ldr1b !== 1'b1 || err !== 1'b0) $display("FAIL good_fleet_a got ldr1b=%b err=%b exp 1/0", ldr1b, err); else passed++;
    // Second A confirm with a bad fleet must be ignored without err.
    place_a = 16'h000F; ok_a = 1; board_b_in = 16'h0700; ok_b = 1; tick(); ok_a = 0; ok_b = 0;
    total++; if (ldr2b !== 1'b1 || ldr1b !== 1'b0) $display("FAIL fleet_b_ldr got ldr2b=%b ldr1b=%b exp 1/0", ldr2b, ldr1b); else passed++;
    total++; if (err !== 1'b0) $display("FAIL repeat_confirm_err got=%b exp=0", err); else passed++;
    tick();
    total++; if (st !== 1'b0 || ldr2b !== 1'b0) $display("FAIL start_cycle got st=%b ldr2b=%b exp 0/0", st, ldr2b); else passed++;
    tick();
    total++; if (st !== 1'b1 || turn_b !== 1'b0) $display("FAIL st_pulse got st=%b turn_b=%b exp 1/0", st, turn_b); else passed++;
  endtask

  task automatic test_hit_miss();
    cursor = 4'd8; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (a_map !== 16'h0100 || st !== 1'b0) $display("FAIL hit_map got=%h st=%b exp=0100 st=0", a_map, st); else passed++;
    total++; if (turn_b !== 1'b0) $display("FAIL hit_res_turn got=%b exp=0", turn_b); else passed++;
    tick();
    total++; if (turn_b !== 1'b1) $display("FAIL to_b_turn got=%b exp=1", turn_b); else passed++;
    b_attack = 16'h0010; ok_b = 1; tick(); ok_b = 0;
    total++; if (b_map !== 16'h0000) $display("FAIL miss_map got=%h exp=0000", b_map); else passed++;
    tick();
    total++; if (turn_b !== 1'b0) $display("FAIL to_a_turn got=%b exp=0", turn_b); else passed++;
  endtask

  task automatic test_rejects();
    cursor = 4'd8; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (err !== 1'b1 || a_map !== 16'h0100) $display("FAIL repeat_fire got err=%b map=%h exp 1/0100", err, a_map); else passed++;
    tick();
    total++; if (err !== 1'b0 || turn_b !== 1'b0) $display("FAIL repeat_fire_stay got err=%b turn_b=%b exp 0/0", err, turn_b); else passed++;
    cursor = 4'd9; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (a_map !== 16'h0300) $display("FAIL hit9_map got=%h exp=0300", a_map); else passed++;
    tick();
    b_attack = 16'h0003; ok_b = 1; tick();
    total++; if (err !== 1'b1) $display("FAIL multihot_err got=%b exp=1", err); else passed++;
    b_attack = 16'h0000; tick();
    total++; if (err !== 1'b1) $display("FAIL zero_attack_err got=%b exp=1", err); else passed++;
    b_attack = 16'h0010; tick(); ok_b = 0;
    total++; if (err !== 1'b1 || b_map !== 16'h0) $display("FAIL repeat_attack got err=%b map=%h exp 1/0000", err, b_map); else passed++;
    cursor = 4'd10; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (a_map !== 16'h0300 || err !== 1'b0) $display("FAIL fire_in_b_turn got map=%h err=%b exp 0300/0", a_map, err); else passed++;
    tick();
    total++; if (turn_b !== 1'b1) $display("FAIL still_b_turn got=%b exp=1", turn_b); else passed++;
    b_attack = 16'h0001; ok_b = 1; tick(); ok_b = 0;
    total++; if (b_map !== 16'h0001) $display("FAIL b_hit_map got=%h exp=0001", b_map); else passed++;
    tick();
    total++; if (turn_b !== 1'b0 || winner !== 2'b00) $display("FAIL back_to_a got turn_b=%b win=%b exp 0/00", turn_b, winner); else passed++;
  endtask

  task automatic test_win();
    cursor = 4'd10; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (a_map !== 16'h0700) $display("FAIL win_map got=%h exp=0700", a_map); else passed++;
    tick();
    total++; if (winner !== 2'b01 || live_b !== 1'b0 || live_a !== 1'b1) $display("FAIL win_a got win=%b live=%b%b exp 01/10", winner, live_a, live_b); else passed++;
    cursor = 4'd0; btn_fire = 1; b_attack = 16'h0004; ok_b = 1; place_a = 16'h0007; ok_a = 1;
    tick();
    btn_fire = 0; ok_b = 0; ok_a = 0;
    total++; if (a_map !== 16'h0700 || b_map !== 16'h0001 || err !== 1'b0 || ldr1b !== 1'b0)
      $display("FAIL over_frozen got a=%h b=%h err=%b ldr1b=%b exp 0700/0001/0/0", a_map, b_map, err, ldr1b); else passed++;
    tick(); tick();
    total++; if (winner !== 2'b01 || turn_b !== 1'b0) $display("FAIL over_hold got win=%b turn_b=%b exp 01/0", winner, turn_b); else passed++;
  endtask

  task automatic test_timeout();
    apply_reset();
    do_place(16'h0007, 16'h0700);
    repeat (TO - 1) tick();
    total++; if (turn_b !== 1'b0) $display("FAIL a_timeout_early got=%b exp=0", turn_b); else passed++;
    tick();
    total++; if (turn_b !== 1'b1 || a_map !== 16'h0 || b_map !== 16'h0) $display("FAIL a_timeout got turn_b=%b maps=%h/%h exp 1/0000/0000", turn_b, a_map, b_map); else passed++;
    repeat (TO - 1) tick();
    total++; if (turn_b !== 1'b1) $display("FAIL b_timeout_early got=%b exp=1", turn_b); else passed++;
    tick();
    total++; if (turn_b !== 1'b0) $display("FAIL b_timeout got=%b exp=0", turn_b); else passed++;
    // Valid shot in the final allowed cycle takes priority over forfeit.
    repeat (TO - 1) tick();
    cursor = 4'd8; btn_fire = 1; tick(); btn_fire = 0;
    total++; if (a_map !== 16'h0100) $display("FAIL shot_at_expiry got=%h exp=0100", a_map); else passed++;
    tick(); tick(); tick();
    total++; if (turn_b !== 1'b1) $display("FAIL pre_reset_b_turn got=%b exp=1", turn_b); else passed++;
    #2 clr_n = 1'b0;
    #1;
    total++; if (a_map !== 16'h0 || b_map !== 16'h0 || turn_b !== 1'b0 || winner !== 2'b00 || live_a !== 1'b1 || live_b !== 1'b1)
      $display("FAIL async_reset got a=%h b=%h turn_b=%b win=%b live=%b%b", a_map, b_map, turn_b, winner, live_a, live_b); else passed++;
    tick(); tick();
    #2 clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({ldr1b, ldr2b, st, err} !== 4'b0) $display("FAIL post_reset_glitch got=%b exp=0000", {ldr1b, ldr2b, st, err}); else passed++;
    end
  endtask

  task automatic test_random_game();
    logic [15:0] fa, fb, sa, sb, ma, mb, bit_c, atk;
    logic [1:0]  exp_w;
    int c;
    apply_reset();
    fa = rand_fleet();
    fb = rand_fleet();
    place_a = rand_bad_fleet(); ok_a = 1; tick(); ok_a = 0;
    total++; if (err !== 1'b1 || ldr1b !== 1'b0) $display("FAIL rnd_bad_fleet got err=%b ldr1b=%b exp 1/0", err, ldr1b); else passed++;
    do_place(fa, fb);
    total++; if (st !== 1'b1) $display("FAIL rnd_start got=%b exp=1", st); else passed++;
    sa = '0; sb = '0; ma = '0; mb = '0; exp_w = 2'b00;
    for (int t = 0; t < 40 && exp_w == 2'b00; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (sa != 0 && $urandom_range(0, 1) == 1) begin
        cursor = 4'(pick_bit(sa, 1'b1)); btn_fire = 1; tick(); btn_fire = 0;
        total++; if (err !== 1'b1 || a_map !== ma) $display("FAIL rnd_a_reject got err=%b map=%h exp 1/%h", err, a_map, ma); else passed++;
      end
      c = pick_bit(sa, 1'b0);
      bit_c = 16'(1) << c;
      cursor = 4'(c); btn_fire = 1; tick(); btn_fire = 0;
      sa = sa | bit_c;
      ma = ma | (bit_c & fb);
      total++; if (a_map !== ma || err !== 1'b0) $display("FAIL rnd_a_shot cell=%0d got=%h err=%b exp=%h", c, a_map, err, ma); else passed++;
      tick();
      if (ma == fb) begin
        exp_w = 2'b01;
      end else begin
        total++; if (turn_b !== 1'b1) $display("FAIL rnd_turn_b got=%b exp=1", turn_b); else passed++;
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0: atk = 16'h0;
            1: atk = (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
            default: atk = (sb != 0) ? (16'(1) << pick_bit(sb, 1'b1)) : 16'hFFFF;
          endcase
          b_attack = atk; ok_b = 1; tick(); ok_b = 0;
          total++; if (err !== 1'b1 || b_map !== mb) $display("FAIL rnd_b_reject atk=%h got err=%b map=%h exp 1/%h", atk, err, b_map, mb); else passed++;
        end
        c = pick_bit(sb, 1'b0);
        bit_c = 16'(1) << c;
        b_attack = bit_c; ok_b = 1; tick(); ok_b = 0;
        sb = sb | bit_c;
        mb = mb | (bit_c & fa);
        total++; if (b_map !== mb) $display("FAIL rnd_b_shot cell=%0d got=%h exp=%h", c, b_map, mb); else passed++;
        tick();
        if (mb == fa) exp_w = 2'b10;
        else begin
          total++; if (turn_b !== 1'b0) $display("FAIL rnd_turn_a got=%b exp=0", turn_b); else passed++;
        end
      end
    end
    tick();
    total++; if (winner !== exp_w) $display("FAIL rnd_winner got=%b exp=%b", winner, exp_w); else passed++;
    total++; if (live_a !== (exp_w != 2'b10) || live_b !== (exp_w != 2'b01))
      $display("FAIL rnd_live got=%b%b exp=%b%b", live_a, live_b, exp_w != 2'b10, exp_w != 2'b01); else passed++;
    total++; if (a_map !== ma || b_map !== mb) $display("FAIL rnd_final_maps got=%h/%h exp=%h/%h", a_map, b_map, ma, mb); else passed++;
  endtask

  initial begin
    test_reset();
    test_placement();
    test_hit_miss();
    test_rejects();
    test_win();
    test_timeout();
    for (int g = 0; g < 4; g++) test_random_game();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
